// File: rtl/gpu_command_scheduler_if.sv
// Host command and rasteriser handshake bundle for gpu_command_scheduler.
interface gpu_command_scheduler_if #(
    parameter int W_BITS = 10,
    parameter int H_BITS = 9,
    parameter int C_BITS = 8,
    parameter int DEPTH  = 4
);
    logic                     command_i;
    logic [3:0]               opcode_i;
    logic [24:0]              parameters_i;
    logic                     cmd_ready_o;
    logic                     overflow_o;
    logic [$clog2(DEPTH):0]   fifo_count_o;
    logic                     busy_o;
    logic                     draw_start_o;
    logic                     draw_type_o;
    logic [W_BITS-1:0]        x1_o;
    logic [W_BITS-1:0]        x2_o;
    logic [H_BITS-1:0]        y1_o;
    logic [H_BITS-1:0]        y2_o;
    logic [W_BITS-1:0]        rad_o;
    logic [C_BITS-1:0]        r_o;
    logic [C_BITS-1:0]        g_o;
    logic [C_BITS-1:0]        b_o;
    logic                     draw_done_i;

    // Host/rasteriser side: issues commands, answers draws with done.
    modport master (
        output command_i, opcode_i, parameters_i, draw_done_i,
        input  cmd_ready_o, overflow_o, fifo_count_o, busy_o, draw_start_o,
               draw_type_o, x1_o, x2_o, y1_o, y2_o, rad_o, r_o, g_o, b_o
    );

    // Scheduler side.
    modport slave (
        input  command_i, opcode_i, parameters_i, draw_done_i,
        output cmd_ready_o, overflow_o, fifo_count_o, busy_o, draw_start_o,
               draw_type_o, x1_o, x2_o, y1_o, y2_o, rad_o, r_o, g_o, b_o
    );
endinterface

// File: rtl/gpu_command_scheduler.sv
// GPU command scheduler: shadow geometry registers, draw FIFO and a
// dispatch FSM handing one draw at a time to the rasteriser.
module gpu_command_scheduler #(
    parameter int W_BITS = 10,
    parameter int H_BITS = 9,
    parameter int C_BITS = 8,
    parameter int DEPTH  = 4
) (
    input logic                    clk,
    input logic                    n_rst,
    gpu_command_scheduler_if.slave bus
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef enum logic [3:0] {
        OP_SOFT_RESET = 4'h0,
        OP_SET_XY1    = 4'h1,
        OP_SET_XY2    = 4'h2,
        OP_SET_RADIUS = 4'h3,
        OP_DRAW_LINE  = 4'h4,
        OP_DRAW_RECT  = 4'h5
    } opcode_t;

    typedef struct packed {
        logic              rect;
        logic [W_BITS-1:0] x1;
        logic [H_BITS-1:0] y1;
        logic [W_BITS-1:0] x2;
        logic [H_BITS-1:0] y2;
        logic [W_BITS-1:0] rad;
        logic [C_BITS-1:0] r;
        logic [C_BITS-1:0] g;
        logic [C_BITS-1:0] b;
    } entry_t;

    state_t              state;
    entry_t              mem [DEPTH];
    entry_t              out_q;
    entry_t              new_entry;
    logic                draw_start;
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                overflow;
    logic [W_BITS-1:0]   sh_x1;
    logic [H_BITS-1:0]   sh_y1;
    logic [W_BITS-1:0]   sh_x2;
    logic [H_BITS-1:0]   sh_y2;
    logic [W_BITS-1:0]   sh_rad;

    logic cmd_ready;
    logic accept;
    logic is_draw;
    logic push;
    logic pop;
    logic flush;
    logic unused_bits;

    assign cmd_ready   = count < CNT_BITS'(DEPTH);
    assign accept      = bus.command_i && cmd_ready;
    assign is_draw     = (bus.opcode_i == OP_DRAW_LINE) || (bus.opcode_i == OP_DRAW_RECT);
    assign push        = accept && is_draw;
    assign flush       = accept && (bus.opcode_i == OP_SOFT_RESET);
    assign pop         = (state == IDLE) && (count != '0);
    assign unused_bits = bus.parameters_i[24];

    // Assemble a queue entry from the pre-edge shadows plus the colour word.
    always_comb begin
        new_entry      = '0;
        new_entry.rect = (bus.opcode_i == OP_DRAW_RECT);
        new_entry.x1   = sh_x1;
        new_entry.y1   = sh_y1;
        new_entry.x2   = sh_x2;
        new_entry.y2   = sh_y2;
        new_entry.rad  = sh_rad;
        new_entry.r    = bus.parameters_i[2*C_BITS +: C_BITS];
        new_entry.g    = bus.parameters_i[C_BITS +: C_BITS];
        new_entry.b    = bus.parameters_i[0 +: C_BITS];
    end

    // FIFO storage; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Command decode: shadow registers, overflow flag and FIFO bookkeeping.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sh_x1    <= '0;
            sh_y1    <= '0;
            sh_x2    <= '0;
            sh_y2    <= '0;
            sh_rad   <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (bus.command_i && !cmd_ready) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                case (bus.opcode_i)
                    OP_SOFT_RESET: begin
                        sh_x1    <= '0;
                        sh_y1    <= '0;
                        sh_x2    <= '0;
                        sh_y2    <= '0;
                        sh_rad   <= '0;
                        overflow <= 1'b0;
                    end
                    OP_SET_XY1: begin
                        sh_x1 <= bus.parameters_i[W_BITS-1:0];
                        sh_y1 <= bus.parameters_i[W_BITS+H_BITS-1:W_BITS];
                    end
                    OP_SET_XY2: begin
                        sh_x2 <= bus.parameters_i[W_BITS-1:0];
                        sh_y2 <= bus.parameters_i[W_BITS+H_BITS-1:W_BITS];
                    end
                    OP_SET_RADIUS: begin
                        sh_rad <= bus.parameters_i[W_BITS-1:0];
                    end
                    default: ;
                endcase
            end
            // A flush wins over a concurrent pop; the popped head still
            // dispatches because the FSM captured it this same edge.
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_BITS'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_BITS'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_BITS'(1);
                end else if (!push && pop) begin
                    count <= count - CNT_BITS'(1);
                end
            end
        end
    end

    // Dispatch FSM: pop head, pulse start one cycle, hold until done.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            out_q      <= '0;
            draw_start <= 1'b0;
        end else begin
            draw_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        out_q <= mem[rd_ptr];
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    draw_start <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (bus.draw_done_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_o  = cmd_ready;
    assign bus.overflow_o   = overflow;
    assign bus.fifo_count_o = count;
    assign bus.busy_o       = (state != IDLE) || (count != '0);
    assign bus.draw_start_o = draw_start;
    assign bus.draw_type_o  = out_q.rect;
    assign bus.x1_o         = out_q.x1;
    assign bus.y1_o         = out_q.y1;
    assign bus.x2_o         = out_q.x2;
    assign bus.y2_o         = out_q.y2;
    assign bus.rad_o        = out_q.rad;
    assign bus.r_o          = out_q.r;
    assign bus.g_o          = out_q.g;
    assign bus.b_o          = out_q.b;
endmodule
